// File: rtl/step_pulse_gen.sv
// Turns signed step commands into a ct direction level plus |step| cn pulses,
// tracking the expected counter value on pos. Optional abort input: STEP_PULSE_GEN_ABORT_EN.
module step_pulse_gen #(
  parameter int WIDTH  = 5,
  parameter int STEP_W = 6,
  parameter int HOLD   = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              cmd_valid,
  input  logic [STEP_W-1:0] cmd_step,
`ifdef STEP_PULSE_GEN_ABORT_EN
  input  logic              abort,
`endif
  output logic              cmd_ready,
  output logic              ct,
  output logic              cn,
  output logic              busy,
  output logic              done,
  output logic [WIDTH-1:0]  pos,
  output logic [2:0]        dbg_state
);

  // Handshake: a command transfers on a rising edge where cmd_valid && cmd_ready;
  // cmd_ready is high only in IDLE outside reset, and nothing is queued.

  localparam int MAG_W  = STEP_W + 1;
  localparam int HOLD_W = (HOLD > 1) ? $clog2(HOLD) : 1;

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_SETUP = 3'd1,
    S_HIGH  = 3'd2,
    S_LOW   = 3'd3,
    S_DONE  = 3'd4
  } state_t;

  state_t             state_q, state_d;
  logic [MAG_W-1:0]   rem_q, rem_d;
  logic [HOLD_W-1:0]  hold_q, hold_d;
  logic               dir_q, dir_d;
  logic               abort_q, abort_d;
  logic [WIDTH-1:0]   pos_q, pos_d;
  logic               ct_q, ct_d;
  logic               cn_q, cn_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;

  logic               abort_in;
  logic               hold_last;
  logic [MAG_W-1:0]   step_ext;
  logic [MAG_W-1:0]   step_mag;

`ifdef STEP_PULSE_GEN_ABORT_EN
  assign abort_in = abort;
`else
  assign abort_in = 1'b0;
`endif

  // One extra bit so the most negative step still has a representable magnitude.
  assign step_ext  = {cmd_step[STEP_W-1], cmd_step};
  assign step_mag  = step_ext[MAG_W-1] ? (~step_ext + 1'b1) : step_ext;
  assign hold_last = (hold_q == HOLD_W'(HOLD - 1));

  always_comb begin
    state_d = state_q;
    rem_d   = rem_q;
    hold_d  = hold_q;
    dir_d   = dir_q;
    abort_d = abort_q;
    case (state_q)
      S_IDLE: begin
        abort_d = 1'b0;
        hold_d  = '0;
        if (cmd_valid) begin
          dir_d   = cmd_step[STEP_W-1];
          rem_d   = step_mag;
          state_d = S_SETUP;
        end
      end
      S_SETUP: begin
        hold_d = '0;
        if (abort_in || (rem_q == '0)) state_d = S_DONE;
        else                           state_d = S_HIGH;
      end
      S_HIGH: begin
        abort_d = abort_q | abort_in;
        if (hold_last) begin
          hold_d  = '0;
          rem_d   = rem_q - 1'b1;
          state_d = S_LOW;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_LOW: begin
        abort_d = abort_q | abort_in;
        if (hold_last) begin
          hold_d  = '0;
          state_d = ((rem_q != '0) && !(abort_q || abort_in)) ? S_HIGH : S_DONE;
        end else begin
          hold_d = hold_q + 1'b1;
        end
      end
      S_DONE: begin
        abort_d = 1'b0;
        state_d = S_IDLE;
      end
      default: state_d = S_IDLE;
    endcase
  end

  // Outputs are registered from the next state so they line up with state_q.
  always_comb begin
    pos_d  = pos_q;
    ct_d   = ct_q;
    cn_d   = (state_d == S_HIGH);
    busy_d = (state_d != S_IDLE);
    done_d = (state_d == S_DONE);
    if (state_d == S_SETUP) ct_d = dir_d;
    if ((state_d == S_HIGH) && (state_q != S_HIGH)) begin
      pos_d = ct_q ? (pos_q - 1'b1) : (pos_q + 1'b1);
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= S_IDLE;
      rem_q   <= '0;
      hold_q  <= '0;
      dir_q   <= 1'b0;
      abort_q <= 1'b0;
      pos_q   <= '0;
      ct_q    <= 1'b0;
      cn_q    <= 1'b0;
      busy_q  <= 1'b0;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      rem_q   <= rem_d;
      hold_q  <= hold_d;
      dir_q   <= dir_d;
      abort_q <= abort_d;
      pos_q   <= pos_d;
      ct_q    <= ct_d;
      cn_q    <= cn_d;
      busy_q  <= busy_d;
      done_q  <= done_d;
    end
  end

  assign cmd_ready = (state_q == S_IDLE) && !rst;
  assign ct        = ct_q;
  assign cn        = cn_q;
  assign busy      = busy_q;
  assign done      = done_q;
  assign pos       = pos_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_step_pulse_gen.sv
// Bench for step_pulse_gen: HOLD=1 instance driven through a pos scoreboard,
// plus a HOLD=3 instance for phase timing and back-to-back acceptance.
module tb_step_pulse_gen;

  logic       clk = 1'b0;
  logic       rst;
  logic       cmd_valid;
  logic [5:0] cmd_step;
  logic       cmd_ready, ct, cn, busy, done;
  logic [4:0] pos;
  logic [2:0] dbg_state;
  logic       abort;

  logic       c3_valid;
  logic [5:0] c3_step;
  logic       c3_ready, c3_ct, c3_cn, c3_busy, c3_done;
  logic [4:0] c3_pos;
  logic [2:0] c3_dbg;
  logic       c3_abort;

  int n_total = 0;
  int n_bad   = 0;

  logic [4:0] exp_q[$];
  logic [4:0] model_pos;
  logic [4:0] track_pos;
  logic       cur_dir;
  logic       prev_cn;
  int         rise_cnt;
  int         done_cnt;

  always #5 clk = ~clk;

  step_pulse_gen #(.WIDTH(5), .STEP_W(6), .HOLD(1)) dut (
    .clk(clk), .rst(rst), .cmd_valid(cmd_valid), .cmd_step(cmd_step),
`ifdef STEP_PULSE_GEN_ABORT_EN
    .abort(abort),
`endif
    .cmd_ready(cmd_ready), .ct(ct), .cn(cn), .busy(busy), .done(done),
    .pos(pos), .dbg_state(dbg_state)
  );

  step_pulse_gen #(.WIDTH(5), .STEP_W(6), .HOLD(3)) dut3 (
    .clk(clk), .rst(rst), .cmd_valid(c3_valid), .cmd_step(c3_step),
`ifdef STEP_PULSE_GEN_ABORT_EN
    .abort(c3_abort),
`endif
    .cmd_ready(c3_ready), .ct(c3_ct), .cn(c3_cn), .busy(c3_busy), .done(c3_done),
    .pos(c3_pos), .dbg_state(c3_dbg)
  );

  task automatic check(input string tag, input int got, input int exp);
    n_total++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s got=%0d exp=%0d", tag, got, exp);
    end
  endtask

  function automatic int iabs(input int v);
    return (v < 0) ? -v : v;
  endfunction

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Every cn rise must carry the commanded direction and move pos by one.
  always @(negedge clk) begin
    if (rst) begin
      track_pos = '0;
      prev_cn   = 1'b0;
    end else begin
      if (cn && !prev_cn) begin
        rise_cnt++;
        track_pos = cur_dir ? (track_pos - 5'd1) : (track_pos + 5'd1);
        check("pulse_pos", pos, track_pos);
        check("pulse_ct", ct, cur_dir);
      end
      if (done) done_cnt++;
      prev_cn = cn;
    end
  end

  // Drive one command and return in cycle 1 after the accept edge.
  task automatic issue(input int step);
    int n;
    n = 0;
    tick();
    cmd_valid = 1'b1;
    cmd_step  = step[5:0];
    cur_dir   = (step < 0);
    rise_cnt  = 0;
    done_cnt  = 0;
    while (!cmd_ready && n < 100) begin
      tick();
      n++;
    end
    check("accept_ready", cmd_ready, 1);
    @(posedge clk);
    tick();
    cmd_valid = 1'b0;
  endtask

  task automatic wait_done(output int cyc);
    cyc = 1;
    while (!done && cyc < 400) begin
      tick();
      cyc++;
    end
  endtask

  task automatic run_cmd(input int step);
    int c;
    int lat;
    logic [4:0] e;
    model_pos = model_pos + step[4:0];
    exp_q.push_back(model_pos);
    lat = 2 + 2 * iabs(step);
    issue(step);
    wait_done(c);
    check("done_lat", c, lat);
    check("ct_dir", ct, (step < 0) ? 1 : 0);
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      check("done_pos", pos, e);
    end else begin
      check("sb_empty", 0, 1);
    end
    tick();
    check("rises", rise_cnt, iabs(step));
    check("done_once", done_cnt, 1);
    check("idle_ready", cmd_ready, 1);
  endtask

  task automatic reset_mid_train();
    int n;
    issue(8);
    n = 0;
    while (rise_cnt < 3 && n < 50) begin
      tick();
      n++;
    end
    check("rst_third_rise", rise_cnt, 3);
    check("rst_cn_before", cn, 1);
    rst = 1'b1;
    tick();
    check("rst_cn", cn, 0);
    check("rst_pos", pos, 0);
    check("rst_busy", busy, 0);
    check("rst_done", done, 0);
    check("rst_ready_low", cmd_ready, 0);
    rst = 1'b0;
    exp_q.delete();
    model_pos = '0;
    tick();
    check("rst_ready_after", cmd_ready, 1);
    tick();
    tick();
    check("rst_no_done", done_cnt, 0);
  endtask

`ifdef STEP_PULSE_GEN_ABORT_EN
  task automatic abort_run();
    int n;
    int c;
    logic [4:0] e;
    model_pos = model_pos + 5'd2;
    exp_q.push_back(model_pos);
    issue(5);
    n = 0;
    while (rise_cnt < 2 && n < 50) begin
      tick();
      n++;
    end
    check("abort_second_rise", cn, 1);
    abort = 1'b1;
    tick();
    abort = 1'b0;
    wait_done(c);
    check("abort_done_seen", done, 1);
    e = exp_q.pop_front();
    check("abort_pos", pos, e);
    tick();
    check("abort_rises", rise_cnt, 2);
    check("abort_done_once", done_cnt, 1);
  endtask
`endif

  task automatic hold3_run();
    int c;
    tick();
    c3_valid = 1'b1;
    c3_step  = 6'd2;
    check("h3_ready", c3_ready, 1);
    @(posedge clk);
    tick();
    for (int cyc = 1; cyc <= 14; cyc++) begin
      check($sformatf("h3_cn_c%0d", cyc), c3_cn,
            (cyc >= 2 && cyc < 14 && ((cyc - 2) % 6) < 3) ? 1 : 0);
      check($sformatf("h3_done_c%0d", cyc), c3_done, (cyc == 14) ? 1 : 0);
      if (cyc < 14) tick();
    end
    check("h3_ready_in_done", c3_ready, 0);
    check("h3_pos", c3_pos, 2);
    check("h3_ct", c3_ct, 0);
    tick();
    check("h3_ready_after", c3_ready, 1);
    check("h3_busy_idle", c3_busy, 0);
    @(posedge clk);
    tick();
    c3_valid = 1'b0;
    check("h3_second_accept", c3_busy, 1);
    c = 1;
    while (!c3_done && c < 100) begin
      tick();
      c++;
    end
    check("h3_second_lat", c, 14);
    check("h3_pos2", c3_pos, 4);
  endtask

  initial begin
    rst       = 1'b1;
    cmd_valid = 1'b0;
    cmd_step  = '0;
    abort     = 1'b0;
    c3_valid  = 1'b0;
    c3_step   = '0;
    c3_abort  = 1'b0;
    model_pos = '0;
    cur_dir   = 1'b0;
    rise_cnt  = 0;
    done_cnt  = 0;
    repeat (3) tick();
    check("reset_ready", cmd_ready, 0);
    check("reset_cn", cn, 0);
    check("reset_ct", ct, 0);
    check("reset_pos", pos, 0);
    check("reset_busy", busy, 0);
    check("reset_done", done, 0);
    check("reset_state", dbg_state, 0);
    rst = 1'b0;
    tick();
    check("post_reset_ready", cmd_ready, 1);

    run_cmd(4);
    run_cmd(-2);
    run_cmd(8);
    run_cmd(-6);
    run_cmd(26);
    run_cmd(4);
    run_cmd(-3);
    run_cmd(0);
    run_cmd(-32);
    for (int i = 0; i < 4; i++) begin
      run_cmd($signed($urandom_range(0, 20)) - 10);
    end

    reset_mid_train();
`ifdef STEP_PULSE_GEN_ABORT_EN
    abort_run();
`endif
    run_cmd(3);
    hold3_run();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

endmodule

// File: doc/step_pulse_gen.md
Name: step_pulse_gen

Overview:
- Command-side driver for the synchronous up/down counter's ct/cn interface.
- Accepts signed step commands (e.g. +4, -2, +8, -6) over a valid/ready handshake. Converts each into a direction level on ct and a train of |step| pulses on cn.
- Keeps a mirror of the expected counter value so the system can check it against the counter's op output.
- Sits between a controller/sequencer and one counter instance.

Parameters:
- WIDTH, 5, counter/mirror width; mirror wraps modulo 2^WIDTH.
- STEP_W, 6, width of the signed two's-complement step command.
- HOLD, 1, clocks per cn phase; each pulse is HOLD cycles high then HOLD cycles low. Must be >= 1.

Ports:
- clk  in  1  system clock; all state changes on rising edge.
- rst  in  1  synchronous, active-high reset.
- cmd_valid  in  1  step command present.
- cmd_step  in  STEP_W  signed step; positive = up, negative = down, zero = no-op.
- cmd_ready  out  1  block can accept a command.
- ct  out  1  direction to counter: 0 = up, 1 = down.
- cn  out  1  count pulse to counter; counter counts once per cn rising edge.
- busy  out  1  command in progress.
- done  out  1  one-cycle pulse when a command completes.
- pos  out  WIDTH  expected counter value.

Behaviour:
- Reset: rst sampled high at a clk edge forces state=IDLE, ct=0, cn=0, pos=0, done=0, busy=0, remaining count=0.
  - cmd_ready=0 in any cycle where rst is high.
  - All outputs are registered except cmd_ready, which is decoded from state and rst.
- States: IDLE, SETUP, HIGH, LOW, DONE.
- IDLE:
  - cmd_ready=1, busy=0, cn=0, ct holds its last value.
  - Accept occurs when cmd_valid && cmd_ready at a clk edge. On accept, latch direction (sign bit of cmd_step) and magnitude.
  - Magnitude is held in STEP_W+1 bits, so the most negative step -2^(STEP_W-1) yields 2^(STEP_W-1) pulses.
  - Next state: SETUP.
- SETUP (exactly 1 cycle):
  - ct = latched direction, cn=0, busy=1. ct is therefore stable one full cycle before the first cn rise.
  - Next state: HIGH if magnitude > 0, else DONE.
- HIGH (HOLD cycles):
  - cn=1.
  - On the edge entering HIGH, pos increments (ct=0) or decrements (ct=1) by 1, modulo 2^WIDTH.
  - Next state: LOW.
- LOW (HOLD cycles):
  - cn=0, remaining count decrements.
  - Next state: HIGH if remaining > 0, else DONE.
- DONE (1 cycle):
  - done=1, busy=1, cmd_ready=0, cn=0.
  - Next state: IDLE.
- Latency: with acceptance at edge E0 and magnitude m, done is high in cycle 2+2*HOLD*m after E0.
  - Zero step gives done in cycle 2, with no cn activity and pos unchanged.
- Command back-to-back rate: next accept is possible no earlier than the cycle after DONE.
- ct changes only in SETUP, never while cn=1 or within a pulse train.
- cmd_step and cmd_valid are ignored outside IDLE; no queuing.
- Reset mid-operation: pulse train stops immediately. cn=0 in the cycle after the reset edge. No done pulse. pos=0.
  - The downstream counter is expected to be reset together with this block.
- Wrap-around: pos wraps 2^WIDTH-1 -> 0 going up and 0 -> 2^WIDTH-1 going down, with no flag.

Optional Feature:
- Macro STEP_PULSE_GEN_ABORT_EN.
- Defined: adds input port abort (1 bit), sampled each clk edge.
  - abort in SETUP -> DONE next cycle, with no pulses.
  - abort in HIGH -> complete the current pulse (finish HIGH hold, then one LOW phase of HOLD cycles), then DONE. pos keeps the already-counted step.
  - abort in LOW -> DONE after the current LOW hold completes.
  - abort in IDLE/DONE has no effect.
  - done still pulses once per command.
- Undefined: no abort port; every accepted command runs to completion.

Test Plan:
- Reset, then commands +4, -2, +8, -6 with HOLD=1 -> cn rises 4, 2, 8, 6 times; ct = 0, 1, 0, 1; pos 0->4->2->10->4; done once per command, in cycle 10 after accept for +4.
- From pos=30, command +4 -> pos 31, 0, 1, 2; then -3 -> 1, 0, 31; ct stable through each train.
- Command 0 -> no cn edge, done in cycle 2 after accept, pos unchanged; then -32 (STEP_W=6) -> 32 pulses with ct=1, pos returns to starting value.
- HOLD=3, command +2 -> cn high 3 cycles, low 3 cycles, twice; done in cycle 14 after accept; cmd_valid held high throughout -> second accept only after DONE.
- rst asserted during the 3rd pulse of +8 -> next cycle cn=0, pos=0, busy=0, no done; cmd_ready=1 the cycle after rst drops.
- With STEP_PULSE_GEN_ABORT_EN: abort during HIGH of the 2nd pulse of +5 -> pulse completes, pos advanced by exactly 2, single done pulse.
